multi_edge_detect: RTL and testbench
====================================

// Module: multi_edge_detect
// PURPOSE
//   Parametrised successor to the single-channel edge/change detectors: NCH independent
//   channels, each with an input synchroniser and a runtime-selected edge mode.
//   Per-channel outputs: one-cycle detection pulse, retriggerable stretched pulse,
//   sticky status with write-1-to-clear. A shared saturating event counter spans all channels.
//   Sits between raw async status lines and the control/status logic.
// PARAMETERS
//   NCH         8   number of channels (>=1)
//   SYNC_STAGES 2   synchroniser flops per channel (0..3; 0 = sig used directly)
//   PULSE_LEN   4   stretched pulse length in cycles (>=1)
//   CNT_W       16  event counter width (>=1)
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst        in   1        asynchronous, active-low reset
//   enable     in   1        1 = detection active; 0 = events suppressed
//   sig        in   NCH      raw input signals
//   mode       in   2*NCH    per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 any
//   clr        in   NCH      per-channel sticky clear (write-1-to-clear)
//   cnt_clr    in   1        clear evt_count
//   detection  out  NCH      one-cycle edge pulse, registered
//   stretched  out  NCH      detection stretched to PULSE_LEN cycles
//   sticky     out  NCH      latched event flag
//   evt_count  out  CNT_W    total events, saturating
// BEHAVIOUR
//   - Reset (rst=0, async): all sync/history flops, detection, stretch counters, sticky,
//     evt_count -> 0 immediately; prime counter -> 0.
//   - Per channel: sync chain -> sync_q; history prev_q <= sync_q every cycle (enable-independent).
//     rise = sync_q & ~prev_q; fall = ~sync_q & prev_q; any = rise | fall.
//     detection[i] <= enable & primed & mode-selected edge; mode 00 never fires.
//   - Latency: transition first sampled at edge E0 -> detection high for exactly the
//     cycle after edge E0+SYNC_STAGES.
//   - Priming: detection masked for first SYNC_STAGES+1 edges after rst release, so
//     levels held high through reset never produce a spurious rise.
//   - mode changes take effect on the next evaluation edge; no pulse is generated by the mode change itself.
//   - Stretch: per-channel counter (clog2(PULSE_LEN+1) bits). Loaded with PULSE_LEN when
//     the detection register is loaded with 1; otherwise decrements to 0.
//     stretched = (count != 0). It rises in the same cycle as detection.
//     Re-detection reloads (retrigger), so back-to-back events merge into one continuous pulse.
//     PULSE_LEN=1 gives stretched == detection. Counting continues while enable=0.
//   - Sticky: set when detection[i]=1. Cleared by clr[i]=1. Set and clear in the same
//     cycle -> set wins. Unaffected by enable.
//   - evt_count: each edge, evt_count <= sat(evt_count + popcount(detection)), where
//     sat clamps at 2^CNT_W-1 and never wraps.
//     cnt_clr=1 -> evt_count <= popcount(detection), so same-cycle events are not lost.
//     The counter reflects a detection pulse one cycle after the pulse is visible.
//   - enable=0: no new detections, so no sticky sets and no count increments.
//     History keeps tracking, so an edge that occurred while disabled never fires after re-enable.
//   - Reset mid-stretch or mid-count: outputs drop to 0 immediately; priming restarts.
// TESTING
//   1. sig=all 1s held through and after reset release, all modes 11 -> detection,
//      sticky and evt_count stay 0 for 20 cycles.
//   2. SYNC_STAGES=2, PULSE_LEN=4, mode[1:0]=01: sig[0] 0->1 sampled at E0 ->
//      detection[0]=1 for one cycle after E0+2; stretched[0] high 4 cycles; sticky[0]=1;
//      evt_count=1 one cycle later; a falling edge on ch0 produces nothing.
//   3. mode ch3=11: sig[3] toggles 3 times, 2 cycles apart -> 3 detection pulses,
//      stretched[3] continuous until 4 cycles after the last pulse, evt_count=3.
//   4. clr[3]=1 in the same cycle as a new detection[3] -> sticky[3] stays 1;
//      clr[3]=1 alone -> sticky[3]=0 next cycle.
//   5. CNT_W=4, all 8 channels mode 11, 3 simultaneous toggles -> evt_count=15 (saturated, no wrap).
//      Then cnt_clr=1 with 2 concurrent detections -> evt_count=2.
//   6. enable=0, toggle sig[5] (mode 11), enable=1 with sig stable -> no detection.
//      Then rst=0 while stretched[5] high -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/multi_edge_detect.sv
// multi_edge_detect: NCH independent edge detectors with input synchronisers,
// runtime-selected edge mode, one-cycle detection pulse, retriggerable stretched
// pulse, write-1-to-clear sticky flag and a shared saturating event counter.
module multi_edge_detect #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [NCH-1:0]   sig_i,
    input  logic [2*NCH-1:0] mode_i,
    input  logic [NCH-1:0]   clr_i,
    input  logic             cnt_clr_i,
    output logic [NCH-1:0]   detection_o,
    output logic [NCH-1:0]   stretched_o,
    output logic [NCH-1:0]   sticky_o,
    output logic [CNT_W-1:0] evt_count_o
);

    localparam int SW    = $clog2(PULSE_LEN + 1);
    localparam int PC_W  = $clog2(NCH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

    logic [NCH-1:0]   sync_q;
    logic [NCH-1:0]   prev_q;
    logic [2:0]       prime_q;
    logic             primed;
    logic [CNT_W-1:0] evt_q;
    logic [CNT_W-1:0] evt_d;

    // Synchroniser chain; with zero stages the raw input feeds the detector.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_q = sig_i;
        end else begin : g_sync
            logic [NCH-1:0] stage_q [SYNC_STAGES];

            // Shift the raw inputs through SYNC_STAGES flops.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        stage_q[k] <= '0;
                    end
                end else begin
                    stage_q[0] <= sig_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end

            assign sync_q = stage_q[SYNC_STAGES-1];
        end
    endgenerate

    // History tracks the synchronised level every cycle, even when disabled,
    // so edges that happen while disabled are never reported later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_q;
        end
    end

    // Priming counter: masks detection until the chain and history hold real
    // samples, so levels high through reset never look like a rising edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prime_q <= '0;
        end else if (!primed) begin
            prime_q <= prime_q + 3'd1;
        end
    end

    assign primed = (prime_q == PRIME_DONE);

    // Per-channel detection, stretch counter and sticky flag.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic          det_q, det_d;
            logic [SW-1:0] str_q, str_d;
            logic          stk_q, stk_d;
            logic          rise, fall, edge_sel;

            // Edge selection by mode, stretch reload/decrement, sticky set-wins-over-clear.
            always_comb begin
                rise     = sync_q[gi] & ~prev_q[gi];
                fall     = ~sync_q[gi] & prev_q[gi];
                edge_sel = 1'b0;
                case (mode_i[2*gi +: 2])
                    2'b01:   edge_sel = rise;
                    2'b10:   edge_sel = fall;
                    2'b11:   edge_sel = rise | fall;
                    default: edge_sel = 1'b0;
                endcase
                det_d = enable_i & primed & edge_sel;
                if (det_d) begin
                    str_d = SW'(PULSE_LEN);
                end else if (str_q != '0) begin
                    str_d = str_q - 1'b1;
                end else begin
                    str_d = str_q;
                end
                stk_d = det_q | (stk_q & ~clr_i[gi]);
            end

            // Per-channel state registers.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    det_q <= 1'b0;
                    str_q <= '0;
                    stk_q <= 1'b0;
                end else begin
                    det_q <= det_d;
                    str_q <= str_d;
                    stk_q <= stk_d;
                end
            end

            assign detection_o[gi] = det_q;
            assign stretched_o[gi] = (str_q != '0);
            assign sticky_o[gi]    = stk_q;
        end
    endgenerate

    // Saturating event count: add this cycle's visible pulses; a clear restarts
    // from those pulses so simultaneous events are not lost.
    always_comb begin
        logic [PC_W-1:0]  pop;
        logic [SUM_W-1:0] base;
        logic [SUM_W-1:0] sum;
        pop = '0;
        for (int i = 0; i < NCH; i++) begin
            pop = pop + PC_W'(detection_o[i]);
        end
        base = cnt_clr_i ? '0 : SUM_W'(evt_q);
        sum  = base + SUM_W'(pop);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            evt_d = '1;
        end else begin
            evt_d = sum[CNT_W-1:0];
        end
    end

    // Event counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_count_o = evt_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect: a table of per-cycle vectors for the
// single-channel and retrigger/sticky behaviour, plus hand-written sequences for
// priming, saturation, counter clear, enable gating and asynchronous reset.
module tb_multi_edge_detect;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  sig;
    logic [15:0] mode;
    logic [7:0]  clr;
    logic        cc;
    logic [7:0]  det, str, stk;
    logic [15:0] cnt;
    logic [7:0]  det_s, str_s, stk_s;
    logic [3:0]  cnt_s;

    int n_checks = 0;
    int n_errors = 0;

    multi_edge_detect #(.NCH(8), .SYNC_STAGES(2), .PULSE_LEN(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .sig_i(sig), .mode_i(mode),
        .clr_i(clr), .cnt_clr_i(cc), .detection_o(det), .stretched_o(str),
        .sticky_o(stk), .evt_count_o(cnt)
    );

    multi_edge_detect #(.NCH(8), .SYNC_STAGES(2), .PULSE_LEN(4), .CNT_W(4)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .sig_i(sig), .mode_i(mode),
        .clr_i(clr), .cnt_clr_i(cc), .detection_o(det_s), .stretched_o(str_s),
        .sticky_o(stk_s), .evt_count_o(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sig;
        logic [7:0]  clr;
        logic        cc;
        logic [7:0]  det;
        logic [7:0]  str;
        logic [7:0]  stk;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mk(logic [7:0] s, logic [7:0] c, logic k,
                                logic [7:0] d, logic [7:0] t, logic [7:0] y, logic [15:0] n);
        vec_t v;
        v.sig = s; v.clr = c; v.cc = k; v.det = d; v.str = t; v.stk = y; v.cnt = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return at the next falling edge.
    task automatic cyc(input logic [7:0] s, input logic [7:0] c, input logic k);
        sig = s; clr = c; cc = k;
        @(negedge clk);
        $display("cyc sig=%h clr=%h cc=%0d en=%0d -> det=%h str=%h stk=%h cnt=%0d cnt_s=%0d",
                 s, c, k, en, det, str, stk, cnt, cnt_s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Row expectations: outputs after the rising edge that samples that row.
        // ch0 rise-only, ch3 any-edge; 2-stage sync gives detection two rows later.
        tbl[0]  = mk(8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 16'd0);
        tbl[1]  = mk(8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 16'd0);
        tbl[2]  = mk(8'h01, 8'h00, 1'b0, 8'h01, 8'h01, 8'h00, 16'd0);
        tbl[3]  = mk(8'h01, 8'h00, 1'b0, 8'h00, 8'h01, 8'h01, 16'd1);
        tbl[4]  = mk(8'h01, 8'h00, 1'b0, 8'h00, 8'h01, 8'h01, 16'd1);
        tbl[5]  = mk(8'h01, 8'h00, 1'b0, 8'h00, 8'h01, 8'h01, 16'd1);
        tbl[6]  = mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 16'd1);
        tbl[7]  = mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 16'd1);
        tbl[8]  = mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 16'd1);
        tbl[9]  = mk(8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h01, 16'd0);
        tbl[10] = mk(8'h08, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 16'd0);
        tbl[11] = mk(8'h08, 8'h00, 1'b0, 8'h00, 8'h00, 8'h01, 16'd0);
        tbl[12] = mk(8'h00, 8'h00, 1'b0, 8'h08, 8'h08, 8'h01, 16'd0);
        tbl[13] = mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h08, 8'h09, 16'd1);
        tbl[14] = mk(8'h08, 8'h00, 1'b0, 8'h08, 8'h08, 8'h09, 16'd1);
        tbl[15] = mk(8'h08, 8'h00, 1'b0, 8'h00, 8'h08, 8'h09, 16'd2);
        tbl[16] = mk(8'h08, 8'h00, 1'b0, 8'h08, 8'h08, 8'h09, 16'd2);
        tbl[17] = mk(8'h08, 8'h00, 1'b0, 8'h00, 8'h08, 8'h09, 16'd3);
        tbl[18] = mk(8'h08, 8'h00, 1'b0, 8'h00, 8'h08, 8'h09, 16'd3);
        tbl[19] = mk(8'h08, 8'h00, 1'b0, 8'h00, 8'h08, 8'h09, 16'd3);
        tbl[20] = mk(8'h08, 8'h00, 1'b0, 8'h00, 8'h00, 8'h09, 16'd3);
        tbl[21] = mk(8'h08, 8'h01, 1'b0, 8'h00, 8'h00, 8'h08, 16'd3);
        tbl[22] = mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h08, 16'd3);
        tbl[23] = mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h08, 16'd3);
        tbl[24] = mk(8'h00, 8'h00, 1'b0, 8'h08, 8'h08, 8'h08, 16'd3);
        tbl[25] = mk(8'h00, 8'h08, 1'b0, 8'h00, 8'h08, 8'h08, 16'd4);
        tbl[26] = mk(8'h00, 8'h08, 1'b0, 8'h00, 8'h08, 8'h00, 16'd4);
        tbl[27] = mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h08, 8'h00, 16'd4);
        tbl[28] = mk(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 16'd4);

        // Levels high through reset must not produce events once released.
        rst_n = 1'b0; en = 1'b1; sig = 8'hFF; mode = 16'hFFFF; clr = 8'h00; cc = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_det", 32'(det), 32'h0);
        check("reset_str", 32'(str), 32'h0);
        check("reset_stk", 32'(stk), 32'h0);
        check("reset_cnt", 32'(cnt), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(8'hFF, 8'h00, 1'b0);
            check($sformatf("prime_det[%0d]", i), 32'(det), 32'h0);
            check($sformatf("prime_stk[%0d]", i), 32'(stk), 32'h0);
            check($sformatf("prime_cnt[%0d]", i), 32'(cnt), 32'h0);
        end

        // Drop all lines with every channel off: nothing may fire.
        mode = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            cyc(8'h00, 8'h00, 1'b0);
            check($sformatf("off_det[%0d]", i), 32'(det), 32'h0);
        end
        mode = 16'h00C1;

        for (int i = 0; i < 29; i++) begin
            cyc(tbl[i].sig, tbl[i].clr, tbl[i].cc);
            check($sformatf("tbl_det[%0d]", i), 32'(det), 32'(tbl[i].det));
            check($sformatf("tbl_str[%0d]", i), 32'(str), 32'(tbl[i].str));
            check($sformatf("tbl_stk[%0d]", i), 32'(stk), 32'(tbl[i].stk));
            check($sformatf("tbl_cnt[%0d]", i), 32'(cnt), 32'(tbl[i].cnt));
        end

        // Saturation: all channels any-edge, three simultaneous toggles = 24 events.
        mode = 16'hFFFF;
        cyc(8'h00, 8'h00, 1'b1);
        check("sat_modechg_det", 32'(det), 32'h0);
        check("sat_clr_cnt", 32'(cnt), 32'd0);
        check("sat_clr_cnt_s", 32'(cnt_s), 32'd0);
        cyc(8'hFF, 8'h00, 1'b0);
        cyc(8'hFF, 8'h00, 1'b0);
        cyc(8'h00, 8'h00, 1'b0);
        check("sat_det1", 32'(det), 32'hFF);
        check("sat_det1_s", 32'(det_s), 32'hFF);
        cyc(8'h00, 8'h00, 1'b0);
        check("sat_cnt8", 32'(cnt), 32'd8);
        check("sat_cnt8_s", 32'(cnt_s), 32'd8);
        cyc(8'hFF, 8'h00, 1'b0);
        cyc(8'hFF, 8'h00, 1'b0);
        check("sat_cnt16", 32'(cnt), 32'd16);
        check("sat_cnt16_s", 32'(cnt_s), 32'd15);
        cyc(8'hFF, 8'h00, 1'b0);
        check("sat_str_merge", 32'(str), 32'hFF);
        cyc(8'hFF, 8'h00, 1'b0);
        check("sat_cnt24", 32'(cnt), 32'd24);
        check("sat_cnt24_s", 32'(cnt_s), 32'd15);
        cyc(8'hFF, 8'h00, 1'b0);
        cyc(8'hFF, 8'h00, 1'b0);
        check("sat_hold_s", 32'(cnt_s), 32'd15);

        // Counter clear in the same cycle as two visible detections.
        cyc(8'hFC, 8'h00, 1'b0);
        cyc(8'hFC, 8'h00, 1'b0);
        cyc(8'hFC, 8'h00, 1'b0);
        check("cc_det", 32'(det), 32'h03);
        cyc(8'hFC, 8'h00, 1'b1);
        check("cc_cnt", 32'(cnt), 32'd2);
        check("cc_cnt_s", 32'(cnt_s), 32'd2);
        cyc(8'hFC, 8'h00, 1'b0);
        check("cc_hold", 32'(cnt), 32'd2);

        // Enable gating: an edge seen while disabled never fires after re-enable.
        cyc(8'hFC, 8'hFF, 1'b0);
        check("en_stk_clr", 32'(stk), 32'h0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(8'hDC, 8'h00, 1'b0);
            check($sformatf("dis_det[%0d]", i), 32'(det), 32'h0);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(8'hDC, 8'h00, 1'b0);
            check($sformatf("reen_det[%0d]", i), 32'(det), 32'h0);
        end
        check("reen_stk", 32'(stk), 32'h0);
        check("reen_cnt", 32'(cnt), 32'd2);

        // Asynchronous reset while stretched[5] is high.
        cyc(8'hFC, 8'h00, 1'b0);
        cyc(8'hFC, 8'h00, 1'b0);
        cyc(8'hFC, 8'h00, 1'b0);
        check("ar_det_pre", 32'(det), 32'h20);
        check("ar_str_pre", 32'(str), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        check("ar_det", 32'(det), 32'h0);
        check("ar_str", 32'(str), 32'h0);
        check("ar_stk", 32'(stk), 32'h0);
        check("ar_cnt", 32'(cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 16'h5555;
        for (int i = 0; i < 10; i++) begin
            cyc(8'hFC, 8'h00, 1'b0);
            check($sformatf("reprime_det[%0d]", i), 32'(det), 32'h0);
        end
        check("reprime_cnt", 32'(cnt), 32'd0);
        cyc(8'hFF, 8'h00, 1'b0);
        cyc(8'hFF, 8'h00, 1'b0);
        cyc(8'hFF, 8'h00, 1'b0);
        check("post_rise_det", 32'(det), 32'h03);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
